// File: rtl/fb_bank_scheduler_pkg.sv
// fb_sched_pkg: shared types and helpers for the triple-buffer bank scheduler.
//   bank_t      : frame bank index (0..NBANK-1)
//   wstate_t    : writer FSM state
//   third_bank  : bank that is neither a nor b (a, b assumed distinct)
package fb_sched_pkg;

  typedef logic [1:0] bank_t;

  localparam int NBANK = 3;

  typedef enum logic [0:0] {
    W_IDLE   = 1'b0,
    W_ACTIVE = 1'b1
  } wstate_t;

  // Walk downward so the lowest free index wins; with a != b exactly one
  // index survives anyway.
  function automatic bank_t third_bank(input bank_t a, input bank_t b);
    bank_t r;
    r = '0;
    for (int i = NBANK - 1; i >= 0; i--) begin
      if (bank_t'(i) != a && bank_t'(i) != b) r = bank_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/fb_bank_scheduler_if.sv
// fb_bank_scheduler_if: frame-sync pulses in, bank ownership/status out.
//   wr_sof/wr_eof : writer frame start / last word (one-cycle pulses)
//   rd_sof        : VGA frame start (one-cycle pulse)
//   pause         : level, freezes the displayed bank
//   wr_bank/rd_bank, wr_base/rd_base : bank ownership and base addresses
//   ready_vld     : a complete undisplayed frame is held
//   drop_cnt/repeat_cnt : saturating event counters
// master = frame source/sink side, slave = scheduler.
interface fb_bank_scheduler_if #(
  parameter int ADDR_W = 20,
  parameter int CNT_W  = 16
);
  import fb_sched_pkg::*;

  logic              wr_sof;
  logic              wr_eof;
  logic              rd_sof;
  logic              pause;
  bank_t             wr_bank;
  bank_t             rd_bank;
  logic [ADDR_W-1:0] wr_base;
  logic [ADDR_W-1:0] rd_base;
  logic              ready_vld;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  repeat_cnt;

  modport master (
    output wr_sof, wr_eof, rd_sof, pause,
    input  wr_bank, rd_bank, wr_base, rd_base, ready_vld, drop_cnt, repeat_cnt
  );

  modport slave (
    input  wr_sof, wr_eof, rd_sof, pause,
    output wr_bank, rd_bank, wr_base, rd_base, ready_vld, drop_cnt, repeat_cnt
  );

endinterface

// File: rtl/fb_bank_scheduler_sat_counter.sv
// fb_sat_counter: event counter that sticks at all-ones.
//   clk25 : clock
//   rst   : synchronous active-high clear
//   inc   : count one event this cycle
//   q     : count value
module fb_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk25,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] r_q;

  always_ff @(posedge clk25) begin
    if (rst)                    r_q <= '0;
    else if (inc && r_q != '1)  r_q <= r_q + 1'b1;
  end

  assign q = r_q;

endmodule

// File: rtl/fb_bank_scheduler.sv
// fb_bank_scheduler: triple-buffer bank scheduler between the core writer
// and the VGA reader. One bank is written (W), one displayed (R); the third
// (X = third_bank(W,R)) holds the newest complete frame when ready_vld=1,
// otherwise it is free.
//   clk25 : clock, all outputs registered
//   rst   : synchronous active-high reset
//   bus   : slave side of fb_bank_scheduler_if (pulses in, banks/counts out)
module fb_bank_scheduler
  import fb_sched_pkg::*;
#(
  parameter int FRAME_WORDS = 307200,
  parameter int ADDR_W      = 20,   // needs 3*FRAME_WORDS <= 2**ADDR_W
  parameter int CNT_W       = 16
) (
  input  logic                clk25,
  input  logic                rst,
  fb_bank_scheduler_if.slave  bus
);

  function automatic logic [ADDR_W-1:0] base_of(input bank_t b);
    case (b)
      2'd1:    return ADDR_W'(FRAME_WORDS);
      2'd2:    return ADDR_W'(2 * FRAME_WORDS);
      default: return '0;
    endcase
  endfunction

  wstate_t           r_wstate;
  bank_t             r_wbank;
  bank_t             r_rbank;
  logic              r_ready;
  logic [ADDR_W-1:0] r_wbase;
  logic [ADDR_W-1:0] r_rbase;

  wstate_t w_wstate_nxt;
  bank_t   w_wbank_nxt;
  bank_t   w_rbank_nxt;
  logic    w_ready_nxt;
  logic    w_rd_evt;
  logic    w_take;
  logic    w_commit;
  logic    w_drop_inc;
  logic    w_rep_inc;

  assign w_rd_evt = bus.rd_sof && !bus.pause;
  assign w_take   = w_rd_evt && r_ready;
  assign w_commit = (r_wstate == W_ACTIVE) && bus.wr_eof;

  // Reader resolves first against the pre-cycle state; the commit then sees
  // the post-reader R/ready, so a same-cycle take frees the old R for W.
  always_comb begin
    w_wbank_nxt = r_wbank;
    w_rbank_nxt = r_rbank;
    w_ready_nxt = r_ready;
    w_drop_inc  = 1'b0;
    w_rep_inc   = w_rd_evt && !r_ready;

    if (w_take) begin
      w_rbank_nxt = third_bank(r_wbank, r_rbank);
      w_ready_nxt = 1'b0;
    end

    // Either case the writer moves to X and the old W becomes READY; if X
    // was already READY its frame is overwritten unseen.
    if (w_commit) begin
      w_drop_inc  = w_ready_nxt;
      w_wbank_nxt = third_bank(r_wbank, w_rbank_nxt);
      w_ready_nxt = 1'b1;
    end
  end

  // An aborted frame (sof while active) restarts in the same bank. An eof
  // and sof together while active commits and immediately opens the next
  // frame in the new bank.
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:   if (bus.wr_sof) w_wstate_nxt = W_ACTIVE;
      W_ACTIVE: if (bus.wr_eof) w_wstate_nxt = bus.wr_sof ? W_ACTIVE : W_IDLE;
      default:  w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_wbank  <= 2'd0;
      r_rbank  <= 2'd2;
      r_ready  <= 1'b0;
      r_wbase  <= '0;
      r_rbase  <= ADDR_W'(2 * FRAME_WORDS);
    end else begin
      r_wstate <= w_wstate_nxt;
      r_wbank  <= w_wbank_nxt;
      r_rbank  <= w_rbank_nxt;
      r_ready  <= w_ready_nxt;
      // From next-state banks so bases never lag the bank outputs.
      r_wbase  <= base_of(w_wbank_nxt);
      r_rbase  <= base_of(w_rbank_nxt);
    end
  end

  fb_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk25 (clk25),
    .rst   (rst),
    .inc   (w_drop_inc),
    .q     (bus.drop_cnt)
  );

  fb_sat_counter #(.CNT_W(CNT_W)) u_repeat_cnt (
    .clk25 (clk25),
    .rst   (rst),
    .inc   (w_rep_inc),
    .q     (bus.repeat_cnt)
  );

  assign bus.wr_bank   = r_wbank;
  assign bus.rd_bank   = r_rbank;
  assign bus.ready_vld = r_ready;
  assign bus.wr_base   = r_wbase;
  assign bus.rd_base   = r_rbase;

endmodule

// File: tb/tb_fb_bank_scheduler.sv
module tb_fb_bank_scheduler;
  import fb_sched_pkg::*;

  localparam int FW     = 307200;
  localparam int ADDR_W = 20;
  localparam int CNT_W  = 4;    // small so saturation is reachable quickly
  localparam int CMAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [1:0]        wb;
    logic [1:0]        rb;
    logic              rdy;
    logic [ADDR_W-1:0] wbase;
    logic [ADDR_W-1:0] rbase;
    logic [CNT_W-1:0]  drop;
    logic [CNT_W-1:0]  rep;
  } obs_t;

  logic clk25 = 1'b0;
  logic rst   = 1'b1;
  always #20 clk25 = ~clk25;

  fb_bank_scheduler_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  fb_bank_scheduler #(.FRAME_WORDS(FW), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk25 (clk25),
    .rst   (rst),
    .bus   (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  obs_t sb[$];

  // reference model state
  int mw, mr, mact, mdrop, mrep;
  bit mrdy;

  function automatic obs_t sample();
    obs_t o;
    o.wb    = bus.wr_bank;
    o.rb    = bus.rd_bank;
    o.rdy   = bus.ready_vld;
    o.wbase = bus.wr_base;
    o.rbase = bus.rd_base;
    o.drop  = bus.drop_cnt;
    o.rep   = bus.repeat_cnt;
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.wb    = 2'(mw);
    o.rb    = 2'(mr);
    o.rdy   = mrdy;
    o.wbase = ADDR_W'(mw * FW);
    o.rbase = ADDR_W'(mr * FW);
    o.drop  = CNT_W'(mdrop);
    o.rep   = CNT_W'(mrep);
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_obs(input string tag, input obs_t obs, input obs_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, check the scoreboard.
  task automatic step(input bit r, input bit ws, input bit we, input bit rs, input bit pz);
    bit pre_act;
    rst = r; bus.wr_sof = ws; bus.wr_eof = we; bus.rd_sof = rs; bus.pause = pz;
    if (r) begin
      mw = 0; mr = 2; mrdy = 0; mact = 0; mdrop = 0; mrep = 0;
    end else begin
      pre_act = (mact != 0);
      if (rs && !pz) begin
        if (mrdy) begin mr = 3 - mw - mr; mrdy = 0; end
        else if (mrep < CMAX) mrep++;
      end
      if (pre_act && we) begin
        if (mrdy && mdrop < CMAX) mdrop++;
        mw = 3 - mw - mr;
        mrdy = 1;
      end
      if (pre_act) mact = we ? int'(ws) : 1;
      else         mact = int'(ws);
    end
    sb.push_back(model_obs());
    @(posedge clk25); #1;
    chk_obs("scoreboard", sample(), sb.pop_front());
  endtask

  task automatic idle(input int n, input bit pz);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, pz);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
  endtask

  task automatic frame(input bit pz);
    step(0, 1, 0, 0, pz);
    idle(3, pz);
    step(0, 0, 1, 0, pz);
  endtask

  initial begin
    bus.wr_sof = 0; bus.wr_eof = 0; bus.rd_sof = 0; bus.pause = 0;
    mw = 0; mr = 2; mrdy = 0; mact = 0; mdrop = 0; mrep = 0;

    // reset values
    do_reset();
    chk("rst_wr_bank", 64'(bus.wr_bank), 64'd0);
    chk("rst_rd_bank", 64'(bus.rd_bank), 64'd2);
    chk("rst_rd_base", 64'(bus.rd_base), 64'd614400);
    chk("rst_ready",   64'(bus.ready_vld), 64'd0);

    // single frame then display
    step(0, 1, 0, 0, 0);
    idle(9, 0);
    step(0, 0, 1, 0, 0);
    chk("f1_wr_bank", 64'(bus.wr_bank), 64'd1);
    chk("f1_ready",   64'(bus.ready_vld), 64'd1);
    chk("f1_rd_bank", 64'(bus.rd_bank), 64'd2);
    step(0, 0, 0, 1, 0);
    chk("f1_take_rd", 64'(bus.rd_bank), 64'd0);
    chk("f1_take_rdy", 64'(bus.ready_vld), 64'd0);
    chk("f1_free_x", 64'(third_bank(bus.wr_bank, bus.rd_bank)), 64'd2);

    // three commits without reader: two drops, last frame is READY
    do_reset();
    repeat (3) frame(0);
    chk("drop2_cnt",  64'(bus.drop_cnt), 64'd2);
    chk("drop2_rdy",  64'(bus.ready_vld), 64'd1);
    chk("drop2_rd",   64'(bus.rd_bank), 64'd2);
    chk("drop2_x",    64'(third_bank(bus.wr_bank, bus.rd_bank)), 64'd0);

    // reader starved
    do_reset();
    repeat (4) step(0, 0, 0, 1, 0);
    chk("rep4_cnt",  64'(bus.repeat_cnt), 64'd4);
    chk("rep4_rd",   64'(bus.rd_bank), 64'd2);
    chk("rep4_base", 64'(bus.rd_base), 64'd614400);

    // pause freezes the display and suppresses repeat counting
    do_reset();
    frame(1);
    step(0, 0, 0, 1, 1);
    frame(1);
    step(0, 0, 0, 1, 1);
    chk("pz_rd",   64'(bus.rd_bank), 64'd2);
    chk("pz_rep",  64'(bus.repeat_cnt), 64'd0);
    chk("pz_drop", 64'(bus.drop_cnt), 64'd1);
    step(0, 0, 0, 1, 0);
    chk("pz_take", 64'(bus.rd_bank), 64'd1);

    // simultaneous take and commit from W=1,R=2,X=0 READY
    do_reset();
    frame(0);
    step(0, 1, 0, 0, 0);
    idle(2, 0);
    step(0, 0, 1, 1, 0);
    chk("sim_rd",   64'(bus.rd_bank), 64'd0);
    chk("sim_wr",   64'(bus.wr_bank), 64'd2);
    chk("sim_rdy",  64'(bus.ready_vld), 64'd1);
    chk("sim_x",    64'(third_bank(bus.wr_bank, bus.rd_bank)), 64'd1);
    chk("sim_cnts", 64'({bus.drop_cnt, bus.repeat_cnt}), 64'd0);

    // counter saturation
    do_reset();
    repeat (CMAX + 3) step(0, 0, 0, 1, 0);
    chk("sat_rep", 64'(bus.repeat_cnt), 64'(CMAX));
    do_reset();
    repeat (CMAX + 3) frame(0);
    chk("sat_drop", 64'(bus.drop_cnt), 64'(CMAX));

    // reset mid-frame, with pulses in the same cycle ignored
    do_reset();
    step(0, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    chk("midrst_wr",  64'(bus.wr_bank), 64'd0);
    chk("midrst_rdy", 64'(bus.ready_vld), 64'd0);

    // randomized traffic with invariants
    begin
      bit pz;
      pz = 0;
      for (int i = 0; i < 20000; i++) begin
        bit r, ws, we, rs;
        r  = ($urandom_range(0, 499) == 0);
        ws = ($urandom_range(0, 19) == 0);
        we = !ws && ($urandom_range(0, 14) == 0);
        rs = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 199) == 0) pz = ~pz;
        step(r, ws, we, rs, pz);
        chk("rnd_distinct", 64'((bus.wr_bank != bus.rd_bank) && (bus.wr_bank < 3) && (bus.rd_bank < 3)), 64'd1);
        chk("rnd_wbase", 64'(bus.wr_base), 64'(int'(bus.wr_bank) * FW));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
